// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch and next-PC sequencer for the multicycle processor.
// On fetch_go it issues a request for the word at PC_Addr and waits for
// the memory handshake. It latches the returned word into the instruction
// register and loads PC+4 into the PC. On update_pc it computes a redirect
// target (PC+4, branch, j/jal or jr) and loads that into the PC instead.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   PC_Addr      current PC value from the PC register
//   fetch_go     control FSM request to fetch at PC_Addr
//   update_pc    control FSM request to commit the next PC chosen by npc_op
//   npc_op       00 PC+4, 01 branch, 10 j/jal, 11 jr
//   branch_taken branch condition, sampled together with update_pc
//   rs_data      register operand used as the jr target
//   imem_req     fetch request, high for the whole outstanding fetch
//   imem_addr    fetch address, held stable while imem_req is high
//   imem_ready   memory has imem_rdata valid this cycle
//   imem_rdata   instruction word from memory
//   ir           instruction register
//   ir_valid     ir holds the word fetched from imem_addr
//   new_PC       registered next-PC value for the PC load port
//   PC_enable    registered one-cycle PC load strobe
//   fetch_err    one-cycle pulse when a misaligned fetch is refused
module pc_fetch_unit #(
  parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_Addr,
  input  logic        fetch_go,
  input  logic        update_pc,
  input  logic [1:0]  npc_op,
  input  logic        branch_taken,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] new_PC,
  output logic        PC_enable,
  output logic        fetch_err
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        pc_enable_q, pc_enable_d;
  logic        fetch_err_q, fetch_err_d;

  logic [31:0] branch_off;
  logic [31:0] target;

  // Redirect target, computed from the PC+4 captured at the last fetch
  // and the instruction register. The branch offset is the sign-extended
  // word displacement, and all sums wrap modulo 2^32.
  always_comb begin
    branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    target     = pc4_q;
    case (npc_op)
      2'b00:   target = pc4_q;
      2'b01:   target = branch_taken ? (pc4_q + branch_off) : pc4_q;
      2'b10:   target = {pc4_q[31:28], ir_q[25:0], 2'b00};
      default: target = rs_data;
    endcase
  end

  // Next-state logic. In IDLE an accepted redirect wins over a fetch
  // request in the same cycle, and the dropped fetch is left for the
  // control FSM to reissue. A redirect is also refused in the cycle right
  // after a PC load, so that PC_enable can never be high on two
  // consecutive cycles. In REQ the control inputs are ignored until the
  // memory answers. There is no timeout.
  always_comb begin
    state_d     = state_q;
    imem_addr_d = imem_addr_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    pc4_d       = pc4_q;
    new_pc_d    = new_pc_q;
    pc_enable_d = 1'b0;
    fetch_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (update_pc && ir_valid_q && !pc_enable_q) begin
          new_pc_d    = target;
          pc_enable_d = 1'b1;
        end else if (fetch_go) begin
          if (PC_Addr[1:0] != 2'b00) begin
            fetch_err_d = 1'b1;
          end else begin
            imem_addr_d = PC_Addr;
            ir_valid_d  = 1'b0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (imem_ready) begin
          ir_d        = imem_rdata;
          ir_valid_d  = 1'b1;
          pc4_d       = imem_addr_q + 32'd4;
          new_pc_d    = imem_addr_q + 32'd4;
          pc_enable_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset returns to IDLE, so an outstanding
  // request is abandoned at once and a late imem_ready has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      imem_addr_q <= 32'h0000_0000;
      ir_q        <= RESET_IR;
      ir_valid_q  <= 1'b0;
      pc4_q       <= 32'h0000_0000;
      new_pc_q    <= 32'h0000_0000;
      pc_enable_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_addr_q <= imem_addr_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      pc4_q       <= pc4_d;
      new_pc_q    <= new_pc_d;
      pc_enable_q <= pc_enable_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = imem_addr_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign new_PC    = new_pc_q;
  assign PC_enable = pc_enable_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. Every expected value below is worked
// out by hand from the instruction encodings and addresses used.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC_Addr;
  logic        fetch_go;
  logic        update_pc;
  logic [1:0]  npc_op;
  logic        branch_taken;
  logic [31:0] rs_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] new_PC;
  logic        PC_enable;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;
  int pulses;

  pc_fetch_unit #(.RESET_IR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PC_Addr(PC_Addr), .fetch_go(fetch_go),
    .update_pc(update_pc), .npc_op(npc_op), .branch_taken(branch_taken),
    .rs_data(rs_data), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ir(ir),
    .ir_valid(ir_valid), .new_PC(new_PC), .PC_enable(PC_enable),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Full fetch with the memory answering 'lat' cycles after the request
  // starts. Leaves the bench one cycle after completion with PC_enable low.
  task automatic doFetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] data, input int lat);
    PC_Addr  = addr;
    fetch_go = 1'b1;
    applyStimulus();
    fetch_go = 1'b0;
    for (int i = 0; i < lat; i++) begin
      checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'd1);
      checkOutput({tag, "_addr"}, imem_addr, addr);
      if (i == lat - 1) begin
        imem_ready = 1'b1;
        imem_rdata = data;
      end
      applyStimulus();
    end
    imem_ready = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    checkOutput({tag, "_req_done"}, {31'b0, imem_req}, 32'd0);
    checkOutput({tag, "_ir"}, ir, data);
    checkOutput({tag, "_irv"}, {31'b0, ir_valid}, 32'd1);
    checkOutput({tag, "_pcen"}, {31'b0, PC_enable}, 32'd1);
    checkOutput({tag, "_npc"}, new_PC, addr + 32'd4);
    applyStimulus();
    checkOutput({tag, "_pcen_off"}, {31'b0, PC_enable}, 32'd0);
  endtask

  // One-cycle redirect request followed by its checks.
  task automatic doUpdate(input string tag, input logic [1:0] op,
                          input logic taken, input logic [31:0] rs,
                          input logic [31:0] exp_pc);
    update_pc    = 1'b1;
    npc_op       = op;
    branch_taken = taken;
    rs_data      = rs;
    applyStimulus();
    update_pc = 1'b0;
    checkOutput({tag, "_pcen"}, {31'b0, PC_enable}, 32'd1);
    checkOutput({tag, "_npc"}, new_PC, exp_pc);
    applyStimulus();
    checkOutput({tag, "_pcen_off"}, {31'b0, PC_enable}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    PC_Addr      = 32'h0000_3000;
    fetch_go     = 1'b0;
    update_pc    = 1'b0;
    npc_op       = 2'b00;
    branch_taken = 1'b0;
    rs_data      = 32'h0;
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
    #23;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_ir", ir, 32'h0);
    checkOutput("rst_irv", {31'b0, ir_valid}, 32'd0);
    checkOutput("rst_npc", new_PC, 32'h0);
    checkOutput("rst_pcen", {31'b0, PC_enable}, 32'd0);
    checkOutput("rst_ferr", {31'b0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    applyStimulus();

    // A redirect without a valid instruction is ignored.
    update_pc = 1'b1;
    npc_op    = 2'b11;
    rs_data   = 32'h0000_1234;
    applyStimulus();
    update_pc = 1'b0;
    checkOutput("upd_novalid_pcen", {31'b0, PC_enable}, 32'd0);
    checkOutput("upd_novalid_npc", new_PC, 32'h0);

    // The first fetch has the memory answering on the third request cycle.
    doFetch("f3000", 32'h0000_3000, 32'h2008_0005, 3);

    // Branch with offset -2 words from pc4 = 0x3008.
    doFetch("f3004", 32'h0000_3004, 32'h1000_FFFE, 1);
    doUpdate("br_taken", 2'b01, 1'b1, 32'h0, 32'h0000_3000);
    doUpdate("br_not", 2'b01, 1'b0, 32'h0, 32'h0000_3008);

    // Jump to {0x0, 0x0000C10, 00} = 0x3040, then a jr to rs_data.
    doFetch("f3008", 32'h0000_3008, 32'h0800_0C10, 2);
    doUpdate("jump", 2'b10, 1'b0, 32'h0, 32'h0000_3040);
    doUpdate("jr", 2'b11, 1'b0, 32'h0000_3100, 32'h0000_3100);
    doUpdate("seq", 2'b00, 1'b0, 32'h0, 32'h0000_300C);

    // A misaligned fetch is refused without touching ir.
    PC_Addr  = 32'h0000_3102;
    fetch_go = 1'b1;
    applyStimulus();
    fetch_go = 1'b0;
    checkOutput("mis_ferr", {31'b0, fetch_err}, 32'd1);
    checkOutput("mis_req", {31'b0, imem_req}, 32'd0);
    checkOutput("mis_ir", ir, 32'h0800_0C10);
    checkOutput("mis_irv", {31'b0, ir_valid}, 32'd1);
    applyStimulus();
    checkOutput("mis_ferr_off", {31'b0, fetch_err}, 32'd0);
    checkOutput("mis_req2", {31'b0, imem_req}, 32'd0);

    // PC+4 wraps around the top of the address space.
    doFetch("fwrap", 32'hFFFF_FFFC, 32'h2400_0001, 1);

    // A redirect beats a fetch request in the same cycle.
    PC_Addr      = 32'h0000_4000;
    fetch_go     = 1'b1;
    update_pc    = 1'b1;
    npc_op       = 2'b11;
    rs_data      = 32'h0000_3200;
    applyStimulus();
    fetch_go  = 1'b0;
    update_pc = 1'b0;
    checkOutput("both_pcen", {31'b0, PC_enable}, 32'd1);
    checkOutput("both_npc", new_PC, 32'h0000_3200);
    checkOutput("both_req", {31'b0, imem_req}, 32'd0);
    applyStimulus();
    checkOutput("both_req2", {31'b0, imem_req}, 32'd0);
    checkOutput("both_pcen_off", {31'b0, PC_enable}, 32'd0);

    // Control pulses during REQ are ignored and only one load occurs.
    PC_Addr  = 32'h0000_3010;
    fetch_go = 1'b1;
    applyStimulus();
    fetch_go  = 1'b1;
    update_pc = 1'b1;
    npc_op    = 2'b11;
    rs_data   = 32'h0000_5000;
    PC_Addr   = 32'h0000_6000;
    pulses    = 0;
    applyStimulus();
    fetch_go  = 1'b0;
    update_pc = 1'b0;
    checkOutput("busy_addr", imem_addr, 32'h0000_3010);
    checkOutput("busy_req", {31'b0, imem_req}, 32'd1);
    pulses += int'(PC_enable);
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0020;
    applyStimulus();
    imem_ready = 1'b0;
    checkOutput("busy_npc", new_PC, 32'h0000_3014);
    checkOutput("busy_ir", ir, 32'h0000_0020);
    for (int i = 0; i < 4; i++) begin
      pulses += int'(PC_enable);
      applyStimulus();
    end
    checkOutput("busy_pulses", pulses, 32'd1);
    checkOutput("busy_req_done", {31'b0, imem_req}, 32'd0);

    // Reset in the middle of a request abandons it.
    PC_Addr  = 32'h0000_3020;
    fetch_go = 1'b1;
    applyStimulus();
    fetch_go = 1'b0;
    checkOutput("mid_req", {31'b0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("mid_rst_addr", imem_addr, 32'h0);
    checkOutput("mid_rst_ir", ir, 32'h0);
    checkOutput("mid_rst_irv", {31'b0, ir_valid}, 32'd0);
    checkOutput("mid_rst_npc", new_PC, 32'h0);
    checkOutput("mid_rst_pcen", {31'b0, PC_enable}, 32'd0);
    checkOutput("mid_rst_ferr", {31'b0, fetch_err}, 32'd0);
    applyStimulus();
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    applyStimulus();
    applyStimulus();
    imem_ready = 1'b0;
    checkOutput("late_ir", ir, 32'h0);
    checkOutput("late_irv", {31'b0, ir_valid}, 32'd0);
    checkOutput("late_req", {31'b0, imem_req}, 32'd0);
    checkOutput("late_pcen", {31'b0, PC_enable}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch and next-PC sequencer for the multicycle processor. It reads the current program counter, fetches the instruction word from instruction memory over a req/ready handshake, and holds it in the instruction register. It drives the program counter's `new_PC`/`PC_enable` load port, both for the sequential PC+4 update at fetch and for the branch, jump and jr redirects requested by the control FSM.

## Interface
- `RESET_IR`, 32'h0000_0000, instruction register value after reset.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PC_Addr`  in  32  current PC value from the PC register.
- `fetch_go`  in  1  control FSM: start fetch at `PC_Addr`.
- `update_pc`  in  1  control FSM: commit a next-PC selected by `npc_op`.
- `npc_op`  in  2  00 = PC+4, 01 = branch, 10 = j/jal, 11 = jr.
- `branch_taken`  in  1  branch condition from the ALU, sampled with `update_pc`.
- `rs_data`  in  32  register operand for jr.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, stable while `imem_req` is 1.
- `imem_ready`  in  1  memory: `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `ir`  out  32  instruction register.
- `ir_valid`  out  1  `ir` holds the instruction fetched from `imem_addr`.
- `new_PC`  out  32  next PC value, registered.
- `PC_enable`  out  1  one-cycle load strobe to the PC, registered.
- `fetch_err`  out  1  one-cycle pulse: fetch refused because the PC is misaligned.

## Operation
- FSM has two states: IDLE and REQ.
- IDLE, `update_pc`=1 and `ir_valid`=1:
  - next cycle `PC_enable`=1 and `new_PC` = target.
  - `fetch_go` in the same cycle is dropped; the control FSM reissues it.
- IDLE, `fetch_go`=1, `PC_Addr[1:0]`≠0:
  - `fetch_err` pulses in the next cycle.
  - State stays IDLE; `ir` and `ir_valid` are unchanged.
- IDLE, `fetch_go`=1, PC aligned:
  - `imem_addr` <= `PC_Addr`, `ir_valid` <= 0, state <= REQ.
- REQ:
  - `imem_req`=1 and `imem_addr` is held.
  - On `imem_ready`=1: `ir` <= `imem_rdata`, `ir_valid` <= 1, `pc4` <= `imem_addr`+4.
  - In the same cycle: `new_PC` <= `imem_addr`+4, `PC_enable` <= 1, state <= IDLE.
  - `fetch_go` and `update_pc` are ignored in REQ. No timeout.
- Target computation (`pc4` is internal):
  - 00: `pc4`.
  - 01: `branch_taken` ? `pc4` + (sext(`ir[15:0]`)<<2) : `pc4`.
  - 10: {`pc4[31:28]`, `ir[25:0]`, 2'b00}.
  - 11: `rs_data` unmodified; misalignment is caught by the next fetch.
- `update_pc` with `ir_valid`=0 is ignored.
- All arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, and branch offsets wrap the same way.
- `PC_enable` is never high for two consecutive cycles.

## Timing
- Reset values:
  - state IDLE.
  - `imem_req`=0, `imem_addr`=0.
  - `ir`=`RESET_IR`, `ir_valid`=0.
  - `new_PC`=0, `PC_enable`=0, `pc4`=0.
  - `fetch_err`=0.
- `fetch_go` sampled at edge N: `imem_req`=1 from edge N through the edge where `imem_ready`=1 is sampled.
- Fetch latency: with `imem_ready` sampled high at edge M, `ir`, `ir_valid` and `PC_enable` are valid after M and the PC register loads at M+1.
- Minimum fetch is `fetch_go` at N, ready at N+1, PC loaded at N+2.
- `update_pc` at edge N: `PC_enable` is high for the N→N+1 cycle, and the PC loads at N+1.
- All outputs are registered; no combinational input-to-output path.
- Reset asserted mid-REQ:
  - `imem_req` drops immediately (asynchronous).
  - The abandoned request is never completed.
  - `imem_ready` is ignored until a new `fetch_go`.

## Test plan
- Reset with `PC_Addr`=32'h0000_3000, then `fetch_go`, `imem_ready` asserted 3 cycles later with `imem_rdata`=32'h2008_0005 -> `imem_req` high 3 cycles with `imem_addr`=32'h0000_3000; `ir`=32'h2008_0005, `ir_valid`=1, one `PC_enable` pulse with `new_PC`=32'h0000_3004.
- After fetching `ir`=32'h1000_FFFE at 32'h0000_3004: `update_pc` with `npc_op`=01, `branch_taken`=1 -> `new_PC`=32'h0000_3000. The same instruction with `branch_taken`=0 -> `new_PC`=32'h0000_3008.
- `ir`=32'h0800_0C10 fetched at 32'h0000_3008: `npc_op`=10 -> `new_PC`=32'h0000_3040. `npc_op`=11 with `rs_data`=32'h0000_3100 -> `new_PC`=32'h0000_3100.
- `PC_Addr`=32'h0000_3102 with `fetch_go` -> `fetch_err` pulses one cycle, `imem_req` stays 0, `ir`/`ir_valid` unchanged. Separately, `PC_Addr`=32'hFFFF_FFFC fetch -> `new_PC`=32'h0000_0000.
- `fetch_go` and `update_pc` asserted in the same IDLE cycle -> only the `update_pc` redirect occurs and no request is issued. `fetch_go`/`update_pc` pulsed during REQ -> ignored, with a single `PC_enable` on completion.
- `rst_n` asserted while `imem_req`=1 -> `imem_req`=0 immediately and all outputs at reset values. After release, a late `imem_ready` does not change `ir`.
